emsg_decomp: RTL and testbench

EMSG_DECOMP -- requirements
Module: emsg_decomp

---
 rtl/emsg_decomp.sv | 128 ++++++++++++
 tb/tb_emsg_decomp.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emsg_decomp.sv
// emsg_decomp: expands a compressed min-sum check-node message word into
// WC signed messages, emitted P per beat over WC/P beats.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   ecomp      {min1, min2, pos, sign[WC-1:0]}, MSB first
//   in_valid   ecomp holds a valid word
//   in_ready   word accepted when in_valid && in_ready at a rising edge
//   out_data   P messages, message j in bits [j*W +: W], two's complement
//   out_valid  out_data / out_beat / out_last are valid
//   out_ready  downstream accepts the current beat
//   out_beat   current beat index (beat b carries messages b*P .. b*P+P-1)
//   out_last   final beat of the word
//
// Build option: define EMSG_DECOMP_OFFSET_EN to subtract OFFSET from every
// magnitude (floored at zero) before the sign is applied.
module emsg_decomp #(
  parameter int W      = 6,
  parameter int WC     = 32,
  parameter int P      = 8,
  parameter int OFFSET = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3*(W-1)+WC-1:0]         ecomp,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [P*W-1:0]                out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [((WC/P)>1 ? $clog2(WC/P) : 1)-1:0] out_beat,
  output logic                          out_last
);

  localparam int MW = W - 1;
  localparam int CW = 3 * MW + WC;
  localparam int NB = WC / P;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = (WC > 1) ? $clog2(WC) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic            rdy_en;
  logic [BW-1:0]   beat;
  logic [MW-1:0]   min1_q, min2_q, pos_q;
  logic [WC-1:0]   sign_q;
  logic            last_beat;
  logic            accept;

  assign last_beat = (beat == BW'(NB - 1));
  assign accept    = in_valid && in_ready;
  assign out_beat  = beat;
  assign out_last  = out_valid && last_beat;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        // rdy_en keeps in_ready low until the first edge after reset release
        in_ready = rdy_en;
        if (in_valid && rdy_en) state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        // a new word may only enter while the last beat is being consumed,
        // so the next word's beat 0 follows without a bubble
        in_ready  = last_beat && out_ready;
        if (out_ready && last_beat && !in_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat   <= '0;
      min1_q <= '0;
      min2_q <= '0;
      pos_q  <= '0;
      sign_q <= '0;
    end else if (accept) begin
      beat   <= '0;
      min1_q <= ecomp[CW-1 -: MW];
      min2_q <= ecomp[CW-1-MW -: MW];
      pos_q  <= ecomp[WC +: MW];
      sign_q <= ecomp[WC-1:0];
    end else if (out_valid && out_ready) begin
      beat   <= last_beat ? '0 : beat + BW'(1);
    end
  end

  // Expansion is purely combinational from the latched fields and beat index,
  // so the outputs stay stable under backpressure and are zero after reset.
  logic [IW-1:0] idx;
  logic [MW-1:0] mag;
  logic [W-1:0]  msg;

  always_comb begin
    out_data = '0;
    idx      = '0;
    mag      = '0;
    msg      = '0;
    for (int unsigned j = 0; j < P; j++) begin
      idx = IW'(int'(beat) * P + int'(j));
      mag = (int'(pos_q) == int'(idx)) ? min2_q : min1_q;
`ifdef EMSG_DECOMP_OFFSET_EN
      mag = (int'(mag) > OFFSET) ? mag - MW'(OFFSET) : '0;
`endif
      msg = sign_q[idx] ? -{1'b0, mag} : {1'b0, mag};
      out_data[j*W +: W] = msg;
    end
  end

endmodule

// File: tb/tb_emsg_decomp.sv
module tb_emsg_decomp;

  localparam int W      = 6;
  localparam int WC     = 32;
  localparam int P      = 8;
  localparam int OFFSET = 1;
  localparam int MW     = W - 1;
  localparam int CW     = 3 * MW + WC;
  localparam int NB     = WC / P;
  localparam int BW     = (NB > 1) ? $clog2(NB) : 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] ecomp = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [P*W-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_beat;
  logic          out_last;

  int n_cmp = 0;
  int n_bad = 0;

  emsg_decomp #(.W(W), .WC(WC), .P(P), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst(rst), .ecomp(ecomp), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_beat(out_beat), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] mk(input int m1, input int m2, input int pos,
                                       input logic [WC-1:0] sign);
    logic [MW-1:0] a, b, c;
    a = MW'(m1);
    b = MW'(m2);
    c = MW'(pos);
    return {a, b, c, sign};
  endfunction

  // Reference: message i = +/- magnitude, magnitude min2 at pos, min1 elsewhere.
  function automatic logic [W-1:0] ref_msg(input logic [CW-1:0] w, input int i);
    int m1, m2, pos, mag, v;
    logic [WC-1:0] sg;
    logic [31:0] v32;
    m1  = int'(w[CW-1 -: MW]);
    m2  = int'(w[CW-1-MW -: MW]);
    pos = int'(w[WC +: MW]);
    sg  = w[WC-1:0];
    mag = (i == pos) ? m2 : m1;
`ifdef EMSG_DECOMP_OFFSET_EN
    mag = (mag > OFFSET) ? mag - OFFSET : 0;
`endif
    v   = sg[i] ? -mag : mag;
    v32 = v;
    return v32[W-1:0];
  endfunction

  function automatic logic [P*W-1:0] ref_beat(input logic [CW-1:0] w, input int b);
    logic [P*W-1:0] r;
    r = '0;
    for (int j = 0; j < P; j++) r[j*W +: W] = ref_msg(w, b * P + j);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({out_valid, out_beat, out_last, out_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b beat=%0d last=%b data=%h, want all 0",
               out_valid, out_beat, out_last, out_data);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_example();
    logic [CW-1:0] w;
    w = mk(3, 9, 5, 32'h0000_0021);
    ecomp = w; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < NB; b++) begin
      #1;
      n_cmp++;
      if ({out_valid, out_beat, out_last, in_ready, out_data} !==
          {1'b1, BW'(b), (b == NB-1), (b == NB-1), ref_beat(w, b)}) begin
        n_bad++;
        $display("FAIL example_beat%0d: got v=%b beat=%0d last=%b rdy=%b data=%h, want beat=%0d data=%h",
                 b, out_valid, out_beat, out_last, in_ready, out_data, b, ref_beat(w, b));
      end
`ifndef EMSG_DECOMP_OFFSET_EN
      if (b == 0) begin
        n_cmp++;
        if (out_data[0 +: W] !== 6'h3D || out_data[5*W +: W] !== 6'h37 || out_data[W +: W] !== 6'h03) begin
          n_bad++;
          $display("FAIL example_const: got msg0=%h msg5=%h msg1=%h, want 3d 37 03",
                   out_data[0 +: W], out_data[5*W +: W], out_data[W +: W]);
        end
      end
`endif
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL example_idle: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] w1, w2, cur;
    w1 = mk(7, 2, 12, 32'hA5A5_0F0F);
    w2 = mk(11, 30, 1, 32'h1234_8001);
    ecomp = w1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    ecomp = w2;
    for (int c = 0; c < 2 * NB; c++) begin
      #1;
      cur = (c < NB) ? w1 : w2;
      n_cmp++;
      if ({out_valid, out_beat, in_ready, out_data} !==
          {1'b1, BW'(c % NB), (c % NB == NB-1), ref_beat(cur, c % NB)}) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: got v=%b beat=%0d rdy=%b data=%h, want beat=%0d data=%h",
                 c, out_valid, out_beat, in_ready, out_data, c % NB, ref_beat(cur, c % NB));
      end
      tick();
      if (c == NB - 1) in_valid = 1'b0;
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] w;
    w = mk(13, 4, 18, 32'hFFFF_0000);
    ecomp = w; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b1;
    ecomp = mk(1, 1, 0, '0);
    tick(); tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if ({out_valid, out_beat, out_last, in_ready, out_data} !==
          {1'b1, BW'(2), 1'b0, 1'b0, ref_beat(w, 2)}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b beat=%0d last=%b rdy=%b data=%h, want beat=2 rdy=0 data=%h",
                 k, out_valid, out_beat, out_last, in_ready, out_data, ref_beat(w, 2));
      end
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    #1;
    n_cmp++;
    if ({out_valid, out_beat, out_last, out_data} !== {1'b1, BW'(3), 1'b1, ref_beat(w, 3)}) begin
      n_bad++;
      $display("FAIL bp_resume: got v=%b beat=%0d last=%b data=%h, want beat=3 data=%h",
               out_valid, out_beat, out_last, out_data, ref_beat(w, 3));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] w;
    w = mk(6, 20, 9, 32'h0F0F_F0F0);
    ecomp = w; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_beat, out_data} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_async: got v=%b beat=%0d data=%h, want all 0", out_valid, out_beat, out_data);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    w = mk(2, 17, 3, 32'h0000_000F);
    ecomp = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_beat, out_data} !== {1'b1, BW'(0), ref_beat(w, 0)}) begin
      n_bad++;
      $display("FAIL mid_reset_restart: got v=%b beat=%0d data=%h, want beat=0 data=%h",
               out_valid, out_beat, out_data, ref_beat(w, 0));
    end
    for (int b = 0; b < NB; b++) tick();
  endtask

  task automatic test_zero_and_offset();
    logic [CW-1:0] w;
    logic [WC-1:0] sg;
    sg = '1;
    for (int t = 0; t < 2; t++) begin
      w = (t == 0) ? mk(0, 5, 20, 32'h0000_0080) : mk(0, 1, 31, sg);
      ecomp = w; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int b = 0; b < NB; b++) begin
        #1;
        n_cmp++;
        if (out_data !== ref_beat(w, b)) begin
          n_bad++;
          $display("FAIL zero_off%0d_beat%0d: got %h, want %h", t, b, out_data, ref_beat(w, b));
        end
        if (t == 0 && b == 0) begin
          n_cmp++;
          if (out_data[7*W +: W] !== '0) begin
            n_bad++;
            $display("FAIL zero_neg: got msg7=%h, want 00", out_data[7*W +: W]);
          end
        end
`ifdef EMSG_DECOMP_OFFSET_EN
        if (t == 1) begin
          n_cmp++;
          if (out_data !== '0) begin
            n_bad++;
            $display("FAIL offset_floor_beat%0d: got %h, want 0", b, out_data);
          end
        end
`endif
        tick();
      end
    end
  endtask

  typedef struct { logic [CW-1:0] w; int b; } beat_t;

  task automatic test_random();
    beat_t q[$];
    beat_t e;
    logic exp_rdy, acc;
    logic [CW-1:0] w;
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < CW; k++) w[k] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) w[CW-1 -: MW] = '0;
      ecomp = w;
      #1;
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      n_cmp++;
      if ({out_valid, in_ready} !== {q.size() != 0, exp_rdy}) begin
        n_bad++;
        $display("FAIL rand_hs%0d: got v=%b rdy=%b, want v=%b rdy=%b",
                 c, out_valid, in_ready, q.size() != 0, exp_rdy);
      end
      if (q.size() != 0) begin
        e = q[0];
        n_cmp++;
        if ({out_beat, out_last, out_data} !== {BW'(e.b), e.b == NB-1, ref_beat(e.w, e.b)}) begin
          n_bad++;
          $display("FAIL rand_data%0d: got beat=%0d last=%b data=%h, want beat=%0d data=%h",
                   c, out_beat, out_last, out_data, e.b, ref_beat(e.w, e.b));
        end
      end
      acc = in_valid && exp_rdy;
      tick();
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (acc) for (int b = 0; b < NB; b++) q.push_back('{w: w, b: b});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int b = 0; b < NB + 1; b++) tick();
  endtask

  initial begin
    test_reset();
    test_example();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_zero_and_offset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
